// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single data-RAM port: core (C) has priority, while D is
// guaranteed a grant after MAX_WAIT consecutive losses. Read data is routed back to its owner.
module ram_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            c_req,
  input  logic            c_we,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW/8-1:0] c_sel,
  input  logic [DW-1:0]   c_wdata,
  output logic            c_ack,
  output logic            c_stall,
  output logic            c_rvalid,
  output logic [DW-1:0]   c_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW/8-1:0] d_sel,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ack,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            ram_ce,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW/8-1:0] ram_sel,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, RD_C, RD_D} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          wait_full;
  logic          c_gnt, d_gnt;

  assign wait_full = (wait_q == CW'(MAX_WAIT));

  // Grant and RAM-port mux; grants are forced low while reset is asserted
  always_comb begin
    d_gnt     = rst_n & d_req & (~c_req | wait_full);
    c_gnt     = rst_n & c_req & ~d_gnt;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if (d_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = d_we;
      ram_addr  = d_addr;
      ram_sel   = d_sel;
      ram_wdata = d_wdata;
    end else if (c_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = c_we;
      ram_addr  = c_addr;
      ram_sel   = c_sel;
      ram_wdata = c_wdata;
    end
  end

  assign c_ack   = c_gnt;
  assign d_ack   = d_gnt;
  assign c_stall = c_req & ~c_gnt;

  // Next-state: starvation counter and read-return owner
  always_comb begin
    wait_d  = '0;
    state_d = IDLE;
    if (d_req && !d_gnt) begin
      wait_d = wait_full ? wait_q : wait_q + CW'(1);
    end
    if (c_gnt && !c_we) begin
      state_d = RD_C;
    end else if (d_gnt && !d_we) begin
      state_d = RD_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign c_rvalid = (state_q == RD_C);
  assign d_rvalid = (state_q == RD_D);
  assign c_rdata  = c_rvalid ? ram_rdata : '0;
  assign d_rdata  = d_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table plus reset, contention and mid-read reset sequences.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_sel, d_sel;
  logic        c_ack, c_stall, c_rvalid, d_ack, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_rdata;
  logic        load;
  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_sel(c_sel), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM model with byte-select writes and 1-cycle read latency
  always @(posedge clk) begin
    if (load) begin
      mem[8]  <= 32'h1111_1111;
      mem[9]  <= 32'h2222_2222;
      mem[12] <= 32'h5A5A_5A5A;
    end else if (ram_ce) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[7:2]];
      end
    end
  end

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_sel;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_sel;
    logic        e_ce, e_c_ack, e_d_ack, e_stall, e_we;
    logic [3:0]  e_sel;
    logic        e_c_rv;
    logic [31:0] e_c_rd;
    logic        e_d_rv;
    logic [31:0] e_d_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata; c_sel = v.c_sel;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata; d_sel = v.d_sel;
  endtask

  task automatic set_idle();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_sel = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_sel = 0;
  endtask

  task automatic set_reads();
    c_req = 1; c_we = 0; c_addr = 32'h20; c_wdata = 0; c_sel = 4'hF;
    d_req = 1; d_we = 0; d_addr = 32'h24; d_wdata = 0; d_sel = 4'hF;
  endtask

  initial begin
    logic [31:0] e_addr, e_wdata;
    //         c_req we addr      wdata         sel  d_req we addr     wdata         sel  ce cak dak stl we sel  crv crd           drv drd
    vecs[0]  = '{1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,  32'h0,  4'h0, 1, 1, 0, 0, 1, 4'hF, 0, 32'h0,        0, 32'h0};
    vecs[1]  = '{1, 0, 32'h10, 32'h0,        4'hF, 0, 0, 32'h0,  32'h0,  4'h0, 1, 1, 0, 0, 0, 4'hF, 0, 32'h0,        0, 32'h0};
    vecs[2]  = '{0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,  32'h0,  4'h0, 0, 0, 0, 0, 0, 4'h0, 1, 32'hDEADBEEF, 0, 32'h0};
    vecs[3]  = '{0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,  32'h0,  4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 32'h0,        0, 32'h0};
    vecs[4]  = '{1, 0, 32'h20, 32'h0,        4'hF, 0, 0, 32'h0,  32'h0,  4'h0, 1, 1, 0, 0, 0, 4'hF, 0, 32'h0,        0, 32'h0};
    vecs[5]  = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 32'h24, 32'h0,  4'hF, 1, 0, 1, 0, 0, 4'hF, 1, 32'h11111111, 0, 32'h0};
    vecs[6]  = '{0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,  32'h0,  4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 32'h0,        1, 32'h22222222};
    vecs[7]  = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 1, 32'h30, 32'hAB, 4'h1, 1, 0, 1, 0, 1, 4'h1, 0, 32'h0,        0, 32'h0};
    vecs[8]  = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 32'h30, 32'h0,  4'hF, 1, 0, 1, 0, 0, 4'hF, 0, 32'h0,        0, 32'h0};
    vecs[9]  = '{0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,  32'h0,  4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 32'h0,        1, 32'h5A5A5AAB};
    vecs[10] = '{1, 0, 32'h20, 32'h0,        4'hF, 1, 0, 32'h24, 32'h0,  4'hF, 1, 1, 0, 0, 0, 4'hF, 0, 32'h0,        0, 32'h0};
    vecs[11] = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 32'h24, 32'h0,  4'hF, 1, 0, 1, 0, 0, 4'hF, 1, 32'h11111111, 0, 32'h0};
    vecs[12] = '{0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,  32'h0,  4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 32'h0,        1, 32'h22222222};
    vecs[13] = '{1, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 0, 32'h0,  32'h0,  4'h0, 1, 1, 0, 0, 1, 4'h0, 0, 32'h0,        0, 32'h0};
    vecs[14] = '{1, 0, 32'h20, 32'h0,        4'hF, 0, 0, 32'h0,  32'h0,  4'h0, 1, 1, 0, 0, 0, 4'hF, 0, 32'h0,        0, 32'h0};
    vecs[15] = '{0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,  32'h0,  4'h0, 0, 0, 0, 0, 0, 4'h0, 1, 32'h11111111, 0, 32'h0};

    // Reset held with both masters requesting
    rst_n = 1'b0;
    load  = 1'b1;
    set_reads();
    repeat (2) @(posedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("rst ram_ce", 32'(ram_ce), 0);
    chk("rst c_ack", 32'(c_ack), 0);
    chk("rst d_ack", 32'(d_ack), 0);
    chk("rst c_rvalid", 32'(c_rvalid), 0);
    chk("rst d_rvalid", 32'(d_rvalid), 0);
    chk("rst c_stall", 32'(c_stall), 1);
    chk("rst c_rdata", c_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst c_ack", 32'(c_ack), 1);
    chk("post-rst d_ack", 32'(d_ack), 0);
    @(posedge clk); #1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;

    // Table-driven vectors, one per cycle
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      e_addr  = vecs[i].e_d_ack ? vecs[i].d_addr  : vecs[i].e_c_ack ? vecs[i].c_addr  : 32'h0;
      e_wdata = vecs[i].e_d_ack ? vecs[i].d_wdata : vecs[i].e_c_ack ? vecs[i].c_wdata : 32'h0;
      @(negedge clk);
      chk($sformatf("v%0d ram_ce", i), 32'(ram_ce), 32'(vecs[i].e_ce));
      chk($sformatf("v%0d c_ack", i), 32'(c_ack), 32'(vecs[i].e_c_ack));
      chk($sformatf("v%0d d_ack", i), 32'(d_ack), 32'(vecs[i].e_d_ack));
      chk($sformatf("v%0d c_stall", i), 32'(c_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d ram_sel", i), 32'(ram_sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d ram_addr", i), ram_addr, e_addr);
      chk($sformatf("v%0d ram_wdata", i), ram_wdata, e_wdata);
      chk($sformatf("v%0d c_rvalid", i), 32'(c_rvalid), 32'(vecs[i].e_c_rv));
      chk($sformatf("v%0d c_rdata", i), c_rdata, vecs[i].e_c_rd);
      chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].e_d_rv));
      chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_d_rd);
      @(posedge clk); #1;
    end

    // Continuous contention: C,C,C,C,D repeating
    for (int i = 0; i < 20; i++) begin
      set_reads();
      @(negedge clk);
      chk($sformatf("cont%0d wait_q", i), 32'(dut.wait_q), 32'(i % 5));
      chk($sformatf("cont%0d c_ack", i), 32'(c_ack), 32'(i % 5 != 4));
      chk($sformatf("cont%0d d_ack", i), 32'(d_ack), 32'(i % 5 == 4));
      chk($sformatf("cont%0d c_stall", i), 32'(c_stall), 32'(i % 5 == 4));
      if (i > 0) begin
        chk($sformatf("cont%0d c_rvalid", i), 32'(c_rvalid), 32'((i - 1) % 5 != 4));
        chk($sformatf("cont%0d d_rvalid", i), 32'(d_rvalid), 32'((i - 1) % 5 == 4));
      end
      @(posedge clk); #1;
    end
    set_idle();
    @(posedge clk); #1;

    // C read acked, then reset pulsed in the following cycle
    set_reads();
    @(negedge clk);
    chk("midrd c_ack", 32'(c_ack), 1);
    @(posedge clk); #1;
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrd rst c_rvalid", 32'(c_rvalid), 0);
    chk("midrd rst state", 32'(dut.state_q), 0);
    chk("midrd rst wait_q", 32'(dut.wait_q), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("midrd rel%0d c_rvalid", i), 32'(c_rvalid), 0);
      chk($sformatf("midrd rel%0d d_rvalid", i), 32'(d_rvalid), 0);
      chk($sformatf("midrd rel%0d state", i), 32'(dut.state_q), 0);
      chk($sformatf("midrd rel%0d wait_q", i), 32'(dut.wait_q), 0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter for the single data-RAM port of `soc_top`. It shares the RAM between the core's MEM-stage load/store port (master C) and a DMA/debug loader port (master D). Core has default priority, and a starvation counter guarantees D forward progress. The block tracks each outstanding synchronous read and routes the returned data to the owning master. It sits between `u_core_top`'s data-memory signals and `u_ram`.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width; `DW/8` byte selects.
- `MAX_WAIT`, 4, consecutive cycles D may lose before it is forced to win; legal range 1..15.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  core access request, held until `c_ack`.
- `c_we`  in  1  core write enable (1 = store).
- `c_addr`  in  AW  core byte address.
- `c_sel`  in  DW/8  core byte selects.
- `c_wdata`  in  DW  core store data.
- `c_ack`  out  1  core request issued to RAM this cycle.
- `c_stall`  out  1  `c_req & ~c_ack`, to the hazard unit.
- `c_rvalid`  out  1  core read data valid.
- `c_rdata`  out  DW  core read data.
- `d_req`, `d_we`, `d_addr`, `d_sel`, `d_wdata`, `d_ack`, `d_rvalid`, `d_rdata`: same widths and meanings for master D; no stall output.
- `ram_ce`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  AW  RAM address.
- `ram_sel`  out  DW/8  RAM byte selects.
- `ram_wdata`  out  DW  RAM write data.
- `ram_rdata`  in  DW  RAM read data, valid one cycle after a read strobe.

## Operation
- At most one access is issued per cycle. The grant is combinational from the request inputs and registered state.
- Grant rule:
  - D wins if `d_req & (~c_req | wait_q == MAX_WAIT)`.
  - Otherwise C wins if `c_req`.
  - Otherwise nothing is issued.
- `ram_*` outputs mux the winner's fields. `ram_ce` = any grant. When there is no grant, `ram_we`, `ram_sel`, `ram_addr` and `ram_wdata` are 0.
- `c_ack` / `d_ack` equal the respective grant. A master samples its ack at the rising edge and may present its next request in the following cycle.
- Starvation counter `wait_q`, 4 bits:
  - Increments, saturating at `MAX_WAIT`, when `d_req & ~d_ack`.
  - Clears when `d_ack` or `~d_req`.
- Read-return FSM, registered:
  - States are IDLE, RD_C and RD_D.
  - On any cycle, next state = RD_C if C is granted a read; RD_D if D is granted a read; else IDLE.
  - Writes never enter RD_*.
- Read return outputs:
  - `c_rvalid` = (state == RD_C); `d_rvalid` = (state == RD_D).
  - `x_rdata` = `ram_rdata` when the matching `x_rvalid` is high, else 0.
- Byte selects pass through unmodified, including all-zero.
- The arbiter does not check for address hazards between masters. Ordering is grant order.

## Timing
- Grant latency: 0 cycles. Ack is in the same cycle as an uncontended request.
- Read latency: `x_rvalid` is high exactly 1 cycle after the read ack. Back-to-back reads from either master sustain 1 per cycle.
- Write completes at the ack edge. No response is generated.
- Under continuous contention, C receives `MAX_WAIT` grants then D receives 1, repeating. `MAX_WAIT` = 1 gives strict alternation.
- Reset values: state IDLE, `wait_q` 0, both `x_rvalid` 0, both `x_rdata` 0.
- While `rst_n` is low: all grants, acks and `ram_ce` are 0, and `c_stall` = `c_req`.
- Reset mid-read: an ack in the cycle before reset assertion produces no `rvalid` after release.

## Test plan
- Reset with `c_req` = `d_req` = 1 held: `ram_ce`, `c_ack`, `d_ack`, `c_rvalid` and `d_rvalid` are all 0, and `c_stall` = 1. Release reset: C is acked in the first cycle.
- C alone writes 0xDEADBEEF to 0x10 (sel 1111), then reads 0x10: `c_ack` in the same cycles, `c_rvalid` one cycle after the read ack with `c_rdata` = 0xDEADBEEF, and `d_rvalid` stays 0.
- Continuous contention, both requesting, `MAX_WAIT` = 4: the ack pattern is C,C,C,C,D repeating for 20 cycles, `wait_q` returns to 0 after each D grant, and `c_stall` is 1 only in the D cycles.
- C reads 0x20 (holding 0x11111111) in cycle n and D reads 0x24 (holding 0x22222222) in cycle n+1:
  - cycle n+1: `c_rvalid` = 1 with 0x11111111.
  - cycle n+2: `d_rvalid` = 1 with 0x22222222.
  - No cross-valid pulses.
- D writes 0x000000AB to 0x30 with sel 0001: `ram_sel` = 0001 and `ram_we` = 1 in the ack cycle. A following D read of 0x30 returns only byte 0 changed.
- C read acked, then `rst_n` pulsed low in the next cycle: after release no `c_rvalid` pulse, state IDLE and `wait_q` 0.
